// File: rtl/serial_reg_bridge.sv
// serial_reg_bridge
// Bridges a 3-wire host shift link (ser_clk / ser_din / ser_sync, plus
// ser_dout) onto a bank of NUM_REGS parallel words in the clk_sys domain.
// Incoming words are committed by a sync event and announced with a
// per-slot strobe; outgoing words are frozen for the duration of a frame.
// Malformed words (short word, overrun) raise a sticky frame_err and, for a
// short word, resynchronise the bridge to slot 0.

module serial_reg_bridge #(
    parameter int WORD_W      = 32,
    parameter int NUM_REGS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk_sys,
    input  logic                         sys_reset_n,
    input  logic                         ser_clk,
    input  logic                         ser_din,
    input  logic                         ser_sync,
    output logic                         ser_dout,
    input  logic [NUM_REGS*WORD_W-1:0]   out_words,
    output logic [NUM_REGS*WORD_W-1:0]   in_words,
    output logic [NUM_REGS-1:0]          in_wstrb,
    output logic                         frame_done,
    output logic                         frame_err,
    input  logic                         err_clr
);

    localparam int SLOT_W = $clog2(NUM_REGS);
    localparam int CNT_W  = $clog2(WORD_W + 1);

    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WORD_W);
    localparam logic [SLOT_W-1:0] SLOT_ZERO = SLOT_W'(0);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_REGS - 1);

    // Synchroniser chains; index 0 is the first flop after the pin.
    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] din_sync_r;
    logic [SYNC_STAGES-1:0] sync_sync_r;
    logic                   clk_prev_r;
    logic                   rise_s;

    // One-cycle link event pulses and the data bit that goes with them.
    logic                   shift_ev_r;
    logic                   commit_ev_r;
    logic                   din_ev_r;

    // Word/frame engine state.
    logic [SLOT_W-1:0]      slot_r;
    logic [CNT_W-1:0]       bit_cnt_r;
    logic [WORD_W-1:0]      rx_sh_r;
    logic [WORD_W-1:0]      tx_sh_r;
    logic [WORD_W-1:0]      snap_r     [NUM_REGS];
    logic [WORD_W-1:0]      in_words_r [NUM_REGS];
    logic [NUM_REGS-1:0]    in_wstrb_r;
    logic                   frame_done_r;
    logic                   frame_err_r;

    logic                   word_full_s;
    logic                   err_set_s;

    assign rise_s = clk_sync_r[SYNC_STAGES-1] & ~clk_prev_r;

    // Bring the three host wires into clk_sys through identical chains so
    // data and sync stay aligned with the detected clock edge.
    always_ff @(posedge clk_sys or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            clk_sync_r  <= '0;
            din_sync_r  <= '0;
            sync_sync_r <= '0;
            clk_prev_r  <= 1'b0;
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ser_clk};
            din_sync_r  <= {din_sync_r[SYNC_STAGES-2:0], ser_din};
            sync_sync_r <= {sync_sync_r[SYNC_STAGES-2:0], ser_sync};
            clk_prev_r  <= clk_sync_r[SYNC_STAGES-1];
        end
    end

    // Turn a synchronised ser_clk rise into a shift or commit pulse.
    always_ff @(posedge clk_sys or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            shift_ev_r  <= 1'b0;
            commit_ev_r <= 1'b0;
            din_ev_r    <= 1'b0;
        end else begin
            shift_ev_r  <= rise_s & ~sync_sync_r[SYNC_STAGES-1];
            commit_ev_r <= rise_s &  sync_sync_r[SYNC_STAGES-1];
            din_ev_r    <= din_sync_r[SYNC_STAGES-1];
        end
    end

    // Classify the current event: overrun shift or short-word commit.
    always_comb begin
        word_full_s = (bit_cnt_r == CNT_FULL);
        err_set_s   = 1'b0;
        if (shift_ev_r && word_full_s) begin
            err_set_s = 1'b1;
        end else if (commit_ev_r && !word_full_s) begin
            err_set_s = 1'b1;
        end else begin
            err_set_s = 1'b0;
        end
    end

    // Shift, commit and idle-tracking engine. While idle at slot 0 the
    // snapshot follows out_words, so the frame freezes at its first shift.
    always_ff @(posedge clk_sys or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            slot_r       <= SLOT_ZERO;
            bit_cnt_r    <= CNT_ZERO;
            rx_sh_r      <= '0;
            tx_sh_r      <= '0;
            in_wstrb_r   <= '0;
            frame_done_r <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) begin
                snap_r[k]     <= '0;
                in_words_r[k] <= '0;
            end
        end else begin
            in_wstrb_r   <= '0;
            frame_done_r <= 1'b0;
            if (shift_ev_r) begin
                // An overrun bit is dropped; only frame_err reacts to it.
                if (!word_full_s) begin
                    rx_sh_r   <= {din_ev_r, rx_sh_r[WORD_W-1:1]};
                    tx_sh_r   <= tx_sh_r >> 1;
                    bit_cnt_r <= bit_cnt_r + CNT_ONE;
                end
            end else if (commit_ev_r) begin
                bit_cnt_r <= CNT_ZERO;
                if (word_full_s) begin
                    in_words_r[slot_r] <= rx_sh_r;
                    in_wstrb_r[slot_r] <= 1'b1;
                    frame_done_r       <= (slot_r == SLOT_LAST);
                    slot_r             <= slot_r + SLOT_ONE;
                end else begin
                    // Short word: throw it away and realign to frame start.
                    slot_r <= SLOT_ZERO;
                end
            end else if (bit_cnt_r == CNT_ZERO) begin
                if (slot_r == SLOT_ZERO) begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        snap_r[k] <= out_words[k*WORD_W +: WORD_W];
                    end
                    tx_sh_r <= out_words[WORD_W-1:0];
                end else begin
                    tx_sh_r <= snap_r[slot_r];
                end
            end
        end
    end

    // Sticky error flag; a new error wins over a simultaneous clear.
    always_ff @(posedge clk_sys or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            frame_err_r <= 1'b0;
        end else if (err_set_s) begin
            frame_err_r <= 1'b1;
        end else if (err_clr) begin
            frame_err_r <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
        assign in_words[g*WORD_W +: WORD_W] = in_words_r[g];
    end

    assign ser_dout   = tx_sh_r[0];
    assign in_wstrb   = in_wstrb_r;
    assign frame_done = frame_done_r;
    assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_serial_reg_bridge.sv
// Testbench for serial_reg_bridge: an 8-bit instance for the functional
// scenarios and a default-parameter instance for the 32-bit word and the
// strobe latency. Committed words are pushed to a scoreboard queue and
// popped by a monitor whenever the 8-bit instance strobes.

module tb_serial_reg_bridge;

    logic        clk_sys = 1'b0;
    logic        sys_reset_n;
    logic        ser_clk8, ser_clk32, ser_din, ser_sync, err_clr;

    logic [31:0]  out8, in8;
    logic [3:0]   wstrb8;
    logic         fd8, fe8, dout8;

    logic [127:0] out32, in32;
    logic [3:0]   wstrb32;
    logic         fd32, fe32, dout32;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int         slot;
        logic [7:0] word;
        logic       fd;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] exp_in8;

    always #5 clk_sys = ~clk_sys;

    serial_reg_bridge #(.WORD_W(8), .NUM_REGS(4), .SYNC_STAGES(2)) dut8 (
        .clk_sys(clk_sys), .sys_reset_n(sys_reset_n), .ser_clk(ser_clk8),
        .ser_din(ser_din), .ser_sync(ser_sync), .ser_dout(dout8),
        .out_words(out8), .in_words(in8), .in_wstrb(wstrb8),
        .frame_done(fd8), .frame_err(fe8), .err_clr(err_clr)
    );

    serial_reg_bridge dut32 (
        .clk_sys(clk_sys), .sys_reset_n(sys_reset_n), .ser_clk(ser_clk32),
        .ser_din(ser_din), .ser_sync(ser_sync), .ser_dout(dout32),
        .out_words(out32), .in_words(in32), .in_wstrb(wstrb32),
        .frame_done(fd32), .frame_err(fe32), .err_clr(err_clr)
    );

    // Scoreboard monitor: every strobe or frame_done of the 8-bit bridge must
    // match the oldest pending commit (slot, word, frame_done).
    always @(negedge clk_sys) begin
        if (sys_reset_n === 1'b1 && (wstrb8 !== 4'b0000 || fd8 !== 1'b0)) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL strobe_unexpected: wstrb=%b frame_done=%b, required no strobe", wstrb8, fd8);
            end else begin
                mon_e = exp_q.pop_front();
                if (wstrb8 !== (4'b0001 << mon_e.slot) || fd8 !== mon_e.fd ||
                    in8[mon_e.slot*8 +: 8] !== mon_e.word) begin
                    $display("FAIL commit_slot%0d: wstrb=%b fd=%b word=%h, required wstrb=%b fd=%b word=%h",
                             mon_e.slot, wstrb8, fd8, in8[mon_e.slot*8 +: 8],
                             4'b0001 << mon_e.slot, mon_e.fd, mon_e.word);
                end else begin
                    passes++;
                end
            end
        end
    end

    // One host link event: set data/sync, hold ser_clk low, then high.
    task automatic ev(input logic big, input logic sy, input logic d);
        @(negedge clk_sys);
        ser_sync = sy;
        ser_din  = d;
        repeat (5) @(negedge clk_sys);
        if (big) ser_clk32 = 1'b1; else ser_clk8 = 1'b1;
        repeat (6) @(negedge clk_sys);
        ser_clk8  = 1'b0;
        ser_clk32 = 1'b0;
    endtask

    // Shift one 8-bit word in (reading ser_dout before each shift), then commit.
    task automatic send_word8(input logic [7:0] w, input int slot, input logic fd,
                              output logic [7:0] rd);
        for (int i = 0; i < 8; i++) begin
            rd[i] = dout8;
            ev(1'b0, 1'b0, w[i]);
        end
        exp_q.push_back('{slot, w, fd});
        exp_in8[slot*8 +: 8] = w;
        ev(1'b0, 1'b1, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk_sys);
        sys_reset_n = 1'b0;
        exp_q.delete();
        exp_in8 = 32'h0;
        repeat (3) @(negedge clk_sys);
        sys_reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic check_queue_drained(input string name);
        checks++;
        if (exp_q.size() != 0) $display("FAIL %s_missing_strobe: pending=%0d, required 0", name, exp_q.size());
        else passes++;
    endtask

    task automatic check_in_words(input string name);
        checks++;
        if (in8 !== exp_in8) $display("FAIL %s_in_words: got %h, required %h", name, in8, exp_in8);
        else passes++;
    endtask

    task automatic check_err(input string name, input logic req);
        checks++;
        if (fe8 !== req) $display("FAIL %s: frame_err=%b, required %b", name, fe8, req);
        else passes++;
    endtask

    task automatic test_reset();
        logic [38:0] all8;
        ser_clk8 = 1'b0; ser_clk32 = 1'b0; ser_din = 1'b0; ser_sync = 1'b0; err_clr = 1'b0;
        out8  = 32'h44332211;
        out32 = {96'h0, 32'hCAFEF00D};
        exp_in8 = 32'h0;
        sys_reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        all8 = {in8, wstrb8, fd8, fe8, dout8};
        checks++;
        if (all8 !== 39'h0) $display("FAIL reset_dut8_outputs: got %h, required 0", all8);
        else passes++;
        checks++;
        if ({in32, wstrb32, fd32, fe32, dout32} !== 135'h0)
            $display("FAIL reset_dut32_outputs: in32=%h wstrb=%b fd=%b fe=%b dout=%b, required all 0",
                     in32, wstrb32, fd32, fe32, dout32);
        else passes++;
        sys_reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic test_loopback(input string name, input logic [31:0] tx_words);
        logic [7:0] rd;
        logic [7:0] exp_rd [4];
        exp_rd[0] = 8'h11; exp_rd[1] = 8'h22; exp_rd[2] = 8'h33; exp_rd[3] = 8'h44;
        for (int s = 0; s < 4; s++) begin
            send_word8(tx_words[s*8 +: 8], s, (s == 3), rd);
            checks++;
            if (rd !== exp_rd[s]) $display("FAIL %s_read_slot%0d: got %h, required %h", name, s, rd, exp_rd[s]);
            else passes++;
        end
        check_in_words(name);
        check_queue_drained(name);
        check_err({name, "_no_err"}, 1'b0);
    endtask

    task automatic test_reset_mid_word();
        for (int i = 0; i < 5; i++) ev(1'b0, 1'b0, 1'b1);
        @(negedge clk_sys);
        sys_reset_n = 1'b0;
        @(negedge clk_sys);
        checks++;
        if ({in8, wstrb8, fd8, fe8, dout8} !== 39'h0)
            $display("FAIL midword_reset_outputs: in=%h wstrb=%b fd=%b fe=%b dout=%b, required all 0",
                     in8, wstrb8, fd8, fe8, dout8);
        else passes++;
        apply_reset();
        test_loopback("after_reset", 32'h8000C35A);
    endtask

    task automatic test_snapshot();
        logic [7:0] rd;
        logic [7:0] w;
        send_word8(8'h12, 0, 1'b0, rd);
        w = 8'h34;
        for (int i = 0; i < 8; i++) begin
            rd[i] = dout8;
            if (i == 3) out8[23:16] = 8'h99;
            ev(1'b0, 1'b0, w[i]);
        end
        exp_q.push_back('{1, w, 1'b0});
        exp_in8[15:8] = w;
        ev(1'b0, 1'b1, 1'b0);
        send_word8(8'h56, 2, 1'b0, rd);
        checks++;
        if (rd !== 8'h33) $display("FAIL snapshot_frozen: got %h, required 33", rd);
        else passes++;
        send_word8(8'h78, 3, 1'b1, rd);
        send_word8(8'h9A, 0, 1'b0, rd);
        checks++;
        if (rd !== 8'h11) $display("FAIL snapshot_next_slot0: got %h, required 11", rd);
        else passes++;
        send_word8(8'hBC, 1, 1'b0, rd);
        send_word8(8'hDE, 2, 1'b0, rd);
        checks++;
        if (rd !== 8'h99) $display("FAIL snapshot_next_slot2: got %h, required 99", rd);
        else passes++;
        send_word8(8'hF0, 3, 1'b1, rd);
        check_in_words("snapshot");
        check_queue_drained("snapshot");
    endtask

    task automatic test_short_word();
        logic [7:0] rd;
        send_word8(8'h5A, 0, 1'b0, rd);
        for (int i = 0; i < 6; i++) ev(1'b0, 1'b0, 1'b1);
        ev(1'b0, 1'b1, 1'b0);
        check_err("short_word_err", 1'b1);
        check_in_words("short_word");
        send_word8(8'hC7, 0, 1'b0, rd);
        check_in_words("resync_slot0");
        check_queue_drained("short_word");
    endtask

    task automatic test_overrun();
        logic [8:0] bits;
        @(negedge clk_sys); err_clr = 1'b1;
        @(negedge clk_sys); err_clr = 1'b0;
        @(negedge clk_sys);
        check_err("err_clr_alone_a", 1'b0);
        bits = 9'h16B;
        for (int i = 0; i < 9; i++) ev(1'b0, 1'b0, bits[i]);
        check_err("overrun_err", 1'b1);
        exp_q.push_back('{1, 8'h6B, 1'b0});
        exp_in8[15:8] = 8'h6B;
        ev(1'b0, 1'b1, 1'b0);
        check_in_words("overrun");
        check_queue_drained("overrun");
        @(negedge clk_sys); err_clr = 1'b1;
        @(negedge clk_sys); err_clr = 1'b0;
        @(negedge clk_sys);
        check_err("err_clr_alone_b", 1'b0);
        // Empty-word commit; err_clr is raised exactly on the cycle that sets the error.
        @(negedge clk_sys);
        ser_sync = 1'b1; ser_din = 1'b0;
        repeat (5) @(negedge clk_sys);
        ser_clk8 = 1'b1;
        repeat (3) @(negedge clk_sys);
        check_err("err_before_set", 1'b0);
        err_clr = 1'b1;
        @(negedge clk_sys);
        err_clr = 1'b0;
        check_err("err_set_beats_clr", 1'b1);
        repeat (2) @(negedge clk_sys);
        ser_clk8 = 1'b0;
        check_err("err_sticky", 1'b1);
    endtask

    task automatic test_default_params();
        logic [31:0] word, rd;
        logic [3:0]  req;
        word = 32'hDEADBEEF;
        for (int i = 0; i < 32; i++) begin
            rd[i] = dout32;
            ev(1'b1, 1'b0, word[i]);
        end
        checks++;
        if (rd !== 32'hCAFEF00D) $display("FAIL dut32_read: got %h, required cafef00d", rd);
        else passes++;
        @(negedge clk_sys);
        ser_sync = 1'b1; ser_din = 1'b0;
        repeat (5) @(negedge clk_sys);
        ser_clk32 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_sys);
            req = (k == 4) ? 4'b0001 : 4'b0000;
            checks++;
            if (wstrb32 !== req || fd32 !== 1'b0)
                $display("FAIL dut32_strobe_cycle%0d: wstrb=%b fd=%b, required wstrb=%b fd=0", k, wstrb32, fd32, req);
            else passes++;
        end
        ser_clk32 = 1'b0;
        checks++;
        if (in32 !== {96'h0, 32'hDEADBEEF}) $display("FAIL dut32_in_words: got %h, required deadbeef in slot 0", in32);
        else passes++;
        checks++;
        if (fe32 !== 1'b0) $display("FAIL dut32_no_err: frame_err=%b, required 0", fe32);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_loopback("loopback", 32'h01FF3CA5);
        test_reset_mid_word();
        test_snapshot();
        test_short_word();
        test_overrun();
        test_default_params();
        repeat (4) @(negedge clk_sys);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
